mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Shares the single-port 8-bit scratch memory between two requesters (port 0, port 1).
//  Serialises accesses, drives the memory's set/address/value inputs, captures its out bus.
//  Returns read data and a one-cycle ack to the granted requester.
//  Round-robin arbitration; out-of-range addresses are rejected without touching memory.
// PARAMETERS
//  DATA_W     8   data width of memory word and requester buses
//  ADDR_W     8   address width of requester and memory buses
//  MEM_DEPTH  8   number of implemented words; addr >= MEM_DEPTH is an error
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       synchronous, active-low reset
//  req[1:0]   in   2       per-port request, held high until ack
//  we[1:0]    in   2       per-port write enable (1 = write, 0 = read)
//  addr0      in   ADDR_W  port 0 address
//  addr1      in   ADDR_W  port 1 address
//  wdata0     in   DATA_W  port 0 write data
//  wdata1     in   DATA_W  port 1 write data
//  ack[1:0]   out  2       one-cycle completion pulse, one-hot or zero
//  err        out  1       valid with ack: 1 = address out of range
//  rdata      out  DATA_W  read data (write: echoes written value); valid with ack
//  mem_set    out  1       to memory set: one-cycle write strobe
//  mem_addr   out  ADDR_W  to memory address
//  mem_value  out  DATA_W  to memory value
//  mem_out    in   DATA_W  from memory out
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, ack=0, err=0, rdata=0, mem_set=0,
//   mem_addr=0, mem_value=0, rr_last=1 (port 0 wins first tie). A transaction in flight is dropped, no ack.
//  FSM IDLE -> ACCESS -> DONE -> IDLE; 3 cycles per transaction, no back-to-back overlap.
//  IDLE: if any req, pick winner, latch gnt/we/addr/wdata, go ACCESS; else stay.
//  ACCESS: mem_addr=latched addr; mem_value=wdata; mem_set=we & in_range (1 cycle only).
//   Out of range: mem_set stays 0, mem_addr is driven 0.
//  DONE: mem_set=0, mem_addr held; rdata <= write ? wdata : mem_out (sampled at DONE entry);
//   out of range: rdata=0, err=1. ack[gnt]=1 for exactly this cycle; update rr_last=gnt; go IDLE.
//  Latency: req seen in IDLE at edge N -> ack high in cycle N+2.
//  Arbitration: single req wins; both -> port != rr_last. req sampled only in IDLE.
//  Requester keeps req/we/addr/wdata stable until ack; inputs after grant latch are ignored.
//  Requester must drop req in the ack cycle; a req still high in the IDLE cycle after DONE is a new request.
//  Request dropped before ack: transaction still completes and acks (no abort).
//  rdata/err hold their value until next DONE.
// CONFIGURATION
//  MEM_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins ties; rr_last unused
//   (tie off). Undefined (default): round-robin as above.
// STRUCTURE
//  Package mem_arb_pkg: state_e {IDLE, ACCESS, DONE} typedef, port index typedef,
//   NUM_PORTS=2 constant.
//  Sub-module mem_arb_pick: combinational winner select from req and rr_last,
//   honours MEM_ARB_FIXED_PRIO_EN. FSM and datapath stay in top.
// TESTING
//  Reset mid-ACCESS with port 0 write 0x5A to addr 3 -> no ack, mem_set=0 next cycle, outputs zero.
//  Port 0 write 0xA5 to addr 2, then port 1 read addr 2 -> ack[1] at +2 cycles, rdata=0xA5, err=0.
//  req=2'b11 repeatedly, both reads -> acks alternate 01,10,01,10; with macro -> all 01 while req0 high.
//  Port 1 write 0x33 to addr 8 (MEM_DEPTH=8) -> mem_set never high, ack[1]=1, err=1, rdata=0.
//  Write addr 7 = 0xFF then read addr 7 -> rdata=0xFF (upper boundary in range).
//  Port 0 holds req after ack -> second transaction starts in IDLE cycle after DONE, ack 3 cycles later.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory access arbiter
package mem_arb_pkg;
    localparam int NUM_PORTS = 2;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef logic port_t;
endpackage

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: requester-side and memory-side buses of the arbiter
interface mem_access_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] we;
    logic [NUM_PORTS-1:0] ack;
    logic [ADDR_W-1:0]    addr0;
    logic [ADDR_W-1:0]    addr1;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    wdata0;
    logic [DATA_W-1:0]    wdata1;
    logic [DATA_W-1:0]    rdata;
    logic [DATA_W-1:0]    mem_value;
    logic [DATA_W-1:0]    mem_out;
    logic                 err;
    logic                 mem_set;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_out,
        input  ack, err, rdata, mem_set, mem_addr, mem_value
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_out,
        output ack, err, rdata, mem_set, mem_addr, mem_value
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between the two requesters
// Build option: MEM_ARB_FIXED_PRIO_EN makes port 0 win every tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  port_t                i_rr_last,
    output port_t                o_gnt
);
`ifdef MEM_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = i_rr_last;
    assign o_gnt    = ~i_req[0];
`else
    assign o_gnt = (&i_req) ? ~i_rr_last : ~i_req[0];
`endif
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: serialises two requesters onto one single-port scratch memory
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_access_arbiter_if.slave bus
);
    state_e               r_state;
    state_e               w_next;
    port_t                w_gnt;
    port_t                w_rr_last;
    port_t                r_gnt;
    logic                 w_we;
    logic                 w_in_range;
    logic                 r_we;
    logic                 r_in_range;
    logic                 r_mem_set;
    logic                 r_err;
    logic [NUM_PORTS-1:0] r_ack;
    logic [ADDR_W-1:0]    w_addr;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic [DATA_W-1:0]    r_mem_value;
    logic [DATA_W-1:0]    r_rdata;

    mem_arb_pick u_pick (
        .i_req     (bus.req),
        .i_rr_last (w_rr_last),
        .o_gnt     (w_gnt)
    );

    assign w_addr     = w_gnt ? bus.addr1 : bus.addr0;
    assign w_wdata    = w_gnt ? bus.wdata1 : bus.wdata0;
    assign w_we       = bus.we[w_gnt];
    assign w_in_range = w_addr < ADDR_W'(MEM_DEPTH);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state: every grant makes one fixed IDLE -> ACCESS -> DONE pass
    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE && |bus.req) w_next = ACCESS;
        if (r_state == ACCESS)           w_next = DONE;
    end

    // Grant latch, memory drive during ACCESS, result and ack during DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt       <= 1'b0;
            r_we        <= 1'b0;
            r_in_range  <= 1'b0;
            r_mem_set   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_value <= '0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_ack     <= '0;
            r_mem_set <= 1'b0;
            if (r_state == IDLE && |bus.req) begin
                r_gnt       <= w_gnt;
                r_we        <= w_we;
                r_in_range  <= w_in_range;
                r_mem_set   <= w_we & w_in_range;
                r_mem_addr  <= w_in_range ? w_addr : '0;
                r_mem_value <= w_wdata;
            end
            if (r_state == ACCESS) begin
                r_ack   <= NUM_PORTS'(1) << r_gnt;
                r_err   <= ~r_in_range;
                r_rdata <= !r_in_range ? '0 : (r_we ? r_mem_value : bus.mem_out);
            end
        end
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_rr_last = 1'b1;
`else
    port_t r_rr_last;

    // Remember the last served port so the other one wins the next tie
    always_ff @(posedge clk) begin
        if (!rst_n)                r_rr_last <= 1'b1;
        else if (r_state == DONE) r_rr_last <= r_gnt;
    end

    assign w_rr_last = r_rr_last;
`endif

    assign bus.ack       = r_ack;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.mem_set   = r_mem_set;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_value = r_mem_value;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: scoreboard bench with a behavioural scratch memory
module tb_mem_access_arbiter;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    int   set_cnt;
    logic [7:0]  mem [0:255];
    logic [10:0] exp_q [$];

    mem_access_arbiter_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    mem_access_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus.mem_out = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_set === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_value;
            set_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.ack !== 2'b00) begin
            logic [10:0] e;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_ack: ack=%b err=%b rdata=%h, none expected", bus.ack, bus.err, bus.rdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.ack, bus.err, bus.rdata} !== e)
                    $display("FAIL scoreboard: ack=%b err=%b rdata=%h, expected ack=%b err=%b rdata=%h",
                             bus.ack, bus.err, bus.rdata, e[10:9], e[8], e[7:0]);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic drive_port(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.req[p] = 1'b1;
        bus.we[p]  = w;
        if (p == 0) begin
            bus.addr0  = a;
            bus.wdata0 = d;
        end else begin
            bus.addr1  = a;
            bus.wdata1 = d;
        end
    endtask

    task automatic run_txn(input int p, input logic w, input logic [7:0] a, input logic [7:0] d,
                           input bit drop_early, output int lat);
        @(negedge clk);
        drive_port(p, w, a, d);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (drop_early) bus.req[p] = 1'b0;
        end while (bus.ack[p] !== 1'b1 && lat < 20);
        bus.req[p] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus.ack, bus.err, bus.rdata} !== 11'd0)
            $display("FAIL reset_outputs: ack=%b err=%b rdata=%h, expected all zero", bus.ack, bus.err, bus.rdata);
        else pass_cnt++;
        total_cnt++;
        if ({bus.mem_set, bus.mem_addr, bus.mem_value} !== 17'd0)
            $display("FAIL reset_mem_bus: set=%b addr=%h value=%h, expected all zero", bus.mem_set, bus.mem_addr, bus.mem_value);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        drive_port(0, 1'b1, 8'd3, 8'h5A);
        @(negedge clk);
        total_cnt++;
        if (bus.mem_set !== 1'b1 || bus.mem_addr !== 8'd3 || bus.mem_value !== 8'h5A)
            $display("FAIL mid_access_drive: set=%b addr=%h value=%h, expected 1/03/5a", bus.mem_set, bus.mem_addr, bus.mem_value);
        else pass_cnt++;
        rst_n = 1'b0;
        bus.req = 2'b00;
        @(negedge clk);
        total_cnt++;
        if ({bus.ack, bus.err, bus.rdata, bus.mem_set, bus.mem_addr, bus.mem_value} !== 28'd0)
            $display("FAIL mid_access_reset: ack=%b err=%b rdata=%h set=%b addr=%h value=%h, expected all zero",
                     bus.ack, bus.err, bus.rdata, bus.mem_set, bus.mem_addr, bus.mem_value);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.ack !== 2'b00)
            $display("FAIL mid_access_no_ack: ack=%b, expected 00", bus.ack);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat;
        int s0;
        s0 = set_cnt;
        exp_q.push_back({2'b01, 1'b0, 8'hA5});
        run_txn(0, 1'b1, 8'd2, 8'hA5, 1'b0, lat);
        total_cnt++;
        if (lat !== 2) $display("FAIL write_latency: got %0d cycles, expected 2", lat);
        else pass_cnt++;
        total_cnt++;
        if (set_cnt - s0 !== 1) $display("FAIL write_strobe: %0d mem_set pulses, expected 1", set_cnt - s0);
        else pass_cnt++;
        exp_q.push_back({2'b10, 1'b0, 8'hA5});
        run_txn(1, 1'b0, 8'd2, 8'h00, 1'b0, lat);
        total_cnt++;
        if (lat !== 2) $display("FAIL read_latency: got %0d cycles, expected 2", lat);
        else pass_cnt++;
    endtask

    task automatic test_upper_boundary();
        int lat;
        exp_q.push_back({2'b01, 1'b0, 8'hFF});
        run_txn(0, 1'b1, 8'd7, 8'hFF, 1'b0, lat);
        exp_q.push_back({2'b01, 1'b0, 8'hFF});
        run_txn(0, 1'b0, 8'd7, 8'h00, 1'b1, lat);
        total_cnt++;
        if (lat !== 2) $display("FAIL dropped_req_ack: got %0d cycles, expected 2", lat);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        int lat;
        int s0;
        s0 = set_cnt;
        exp_q.push_back({2'b10, 1'b1, 8'h00});
        run_txn(1, 1'b1, 8'd8, 8'h33, 1'b0, lat);
        total_cnt++;
        if (set_cnt - s0 !== 0) $display("FAIL oor_strobe: %0d mem_set pulses, expected 0", set_cnt - s0);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 2) $display("FAIL oor_latency: got %0d cycles, expected 2", lat);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int gap;
        logic [1:0] want;
        @(negedge clk);
        drive_port(0, 1'b0, 8'd2, 8'h00);
        drive_port(1, 1'b0, 8'd7, 8'h00);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            want = 2'b01;
`else
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            exp_q.push_back({want, 1'b0, want[0] ? 8'hA5 : 8'hFF});
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (bus.ack === 2'b00 && gap < 20);
            if (i == 3) bus.req = 2'b00;
            total_cnt++;
            if (gap !== ((i == 0) ? 2 : 3))
                $display("FAIL rr_spacing_%0d: got %0d cycles, expected %0d", i, gap, (i == 0) ? 2 : 3);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        @(negedge clk);
        drive_port(0, 1'b0, 8'd2, 8'h00);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({2'b01, 1'b0, 8'hA5});
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (bus.ack[0] !== 1'b1 && gap < 20);
            if (i == 1) bus.req[0] = 1'b0;
            total_cnt++;
            if (gap !== ((i == 0) ? 2 : 3))
                $display("FAIL b2b_spacing_%0d: got %0d cycles, expected %0d", i, gap, (i == 0) ? 2 : 3);
            else pass_cnt++;
        end
        repeat (4) @(negedge clk);
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL missing_acks: %0d still pending, expected 0", exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        set_cnt   = 0;
        rst_n     = 1'b0;
        bus.req    = 2'b00;
        bus.we     = 2'b00;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
        test_reset();
        test_reset_mid_access();
        test_write_read();
        test_upper_boundary();
        test_out_of_range();
        test_round_robin();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
